// File: rtl/multiexp_add_arb.sv
// Round-robin scheduler feeding one shared pipelined EC point adder from NUM_REQ bucket
// accumulators; tags each op with its requester, tracks ops in flight and routes results by tag.
module multiexp_add_arb #(
  parameter int NUM_REQ      = 4,
  parameter int DAT_BITS     = 768,
  parameter int MAX_INFLIGHT = 16,
  parameter int TAG_BITS     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req_val,
  input  logic [NUM_REQ*DAT_BITS-1:0] i_req_pt_a,
  input  logic [NUM_REQ*DAT_BITS-1:0] i_req_pt_b,
  output logic [NUM_REQ-1:0]          o_req_rdy,
  output logic                        o_add_val,
  output logic [DAT_BITS-1:0]         o_add_pt_a,
  output logic [DAT_BITS-1:0]         o_add_pt_b,
  output logic [TAG_BITS-1:0]         o_add_tag,
  input  logic                        i_add_rdy,
  input  logic                        i_res_val,
  input  logic [DAT_BITS-1:0]         i_res_pt,
  input  logic [TAG_BITS-1:0]         i_res_tag,
  output logic                        o_res_rdy,
  output logic [NUM_REQ-1:0]          o_req_res_val,
  output logic [DAT_BITS-1:0]         o_req_res_pt,
  input  logic [NUM_REQ-1:0]          i_req_res_rdy,
  output logic [7:0]                  o_inflight,
  output logic                        o_err
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_e;

  stage_e              state_q, state_d;
  logic [TAG_BITS-1:0] ptr_q, ptr_d, tag_q, tag_d;
  logic [DAT_BITS-1:0] pt_a_q, pt_a_d, pt_b_q, pt_b_d;
  logic [7:0]          inflight_q, inflight_d;
  logic                err_q, err_d;

  logic                add_hs, res_hs, stage_free, credit_ok, grant, grant_found;
  logic                res_tag_ok, res_sel_rdy;
  logic [TAG_BITS-1:0] grant_idx, cand;
  logic [8:0]          occupancy;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin : rr_scan
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = TAG_BITS'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && i_req_val[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Occupancy counts the staged op too, so a grant can never push the adder past the limit.
  assign add_hs     = (state_q == ST_FULL) & i_add_rdy;
  assign stage_free = (state_q == ST_EMPTY) | add_hs;
  assign occupancy  = {1'b0, inflight_q} + {8'd0, state_q == ST_FULL};
  assign credit_ok  = occupancy < 9'(MAX_INFLIGHT);
  assign grant      = stage_free & credit_ok & grant_found;

  always_comb begin : req_ready
    o_req_rdy = '0;
    if (grant && i_rst) o_req_rdy[grant_idx] = 1'b1;
  end

  always_comb begin : res_route
    res_tag_ok    = 1'b0;
    res_sel_rdy   = 1'b0;
    o_req_res_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_res_tag == TAG_BITS'(i)) begin
        res_tag_ok       = 1'b1;
        res_sel_rdy      = i_req_res_rdy[i];
        o_req_res_val[i] = i_res_val & i_rst;
      end
    end
  end

  // A result carrying an impossible tag is swallowed so it cannot block the result path.
  assign o_res_rdy    = i_rst & (res_tag_ok ? res_sel_rdy : 1'b1);
  assign o_req_res_pt = i_rst ? i_res_pt : '0;
  assign res_hs       = i_res_val & o_res_rdy;

  always_comb begin : next_state
    state_d    = state_q;
    ptr_d      = ptr_q;
    tag_d      = tag_q;
    pt_a_d     = pt_a_q;
    pt_b_d     = pt_b_q;
    inflight_d = inflight_q;
    err_d      = err_q | (i_res_val & ~res_tag_ok) | (res_hs & (inflight_q == 8'd0));

    if (grant) begin
      state_d = ST_FULL;
      ptr_d   = grant_idx;
      tag_d   = grant_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_idx == TAG_BITS'(i)) begin
          pt_a_d = i_req_pt_a[i*DAT_BITS +: DAT_BITS];
          pt_b_d = i_req_pt_b[i*DAT_BITS +: DAT_BITS];
        end
      end
    end else if (add_hs) begin
      state_d = ST_EMPTY;
    end

    case ({add_hs, res_hs})
      2'b10:   inflight_d = inflight_q + 8'd1;
      2'b01:   if (inflight_q != 8'd0) inflight_d = inflight_q - 8'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments only; the operand registers are reset as well
  // because the adder-facing data bus must read zero while reset is asserted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= TAG_BITS'(NUM_REQ - 1);
      tag_q      <= '0;
      pt_a_q     <= '0;
      pt_b_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tag_q      <= tag_d;
      pt_a_q     <= pt_a_d;
      pt_b_q     <= pt_b_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign o_add_val  = (state_q == ST_FULL);
  assign o_add_pt_a = pt_a_q;
  assign o_add_pt_b = pt_b_q;
  assign o_add_tag  = tag_q;
  assign o_inflight = inflight_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_multiexp_add_arb.sv
// Bench for multiexp_add_arb: directed scenarios plus a randomized run against a transaction-level
// model (last-granted pointer, granted/issued/returned counters, queue of ops inside the adder).
module tb_multiexp_add_arb;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 4 requesters, limit 16
  logic [3:0]      a_req_val, a_req_rdy, a_req_res_val, a_req_res_rdy;
  logic [4*DW-1:0] a_req_pt_a, a_req_pt_b;
  logic            a_add_val, a_add_rdy, a_res_val, a_res_rdy, a_err;
  logic [DW-1:0]   a_add_pt_a, a_add_pt_b, a_res_pt, a_req_res_pt;
  logic [1:0]      a_add_tag, a_res_tag;
  logic [7:0]      a_inflight;

  // Instance B: 3 requesters, limit 4
  logic [2:0]      b_req_val, b_req_rdy, b_req_res_val, b_req_res_rdy;
  logic [3*DW-1:0] b_req_pt_a, b_req_pt_b;
  logic            b_add_val, b_add_rdy, b_res_val, b_res_rdy, b_err;
  logic [DW-1:0]   b_add_pt_a, b_add_pt_b, b_res_pt, b_req_res_pt;
  logic [1:0]      b_add_tag, b_res_tag;
  logic [7:0]      b_inflight;

  multiexp_add_arb #(.NUM_REQ(4), .DAT_BITS(DW), .MAX_INFLIGHT(16)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_val(a_req_val), .i_req_pt_a(a_req_pt_a), .i_req_pt_b(a_req_pt_b), .o_req_rdy(a_req_rdy),
    .o_add_val(a_add_val), .o_add_pt_a(a_add_pt_a), .o_add_pt_b(a_add_pt_b), .o_add_tag(a_add_tag),
    .i_add_rdy(a_add_rdy), .i_res_val(a_res_val), .i_res_pt(a_res_pt), .i_res_tag(a_res_tag),
    .o_res_rdy(a_res_rdy), .o_req_res_val(a_req_res_val), .o_req_res_pt(a_req_res_pt),
    .i_req_res_rdy(a_req_res_rdy), .o_inflight(a_inflight), .o_err(a_err)
  );

  multiexp_add_arb #(.NUM_REQ(3), .DAT_BITS(DW), .MAX_INFLIGHT(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req_val(b_req_val), .i_req_pt_a(b_req_pt_a), .i_req_pt_b(b_req_pt_b), .o_req_rdy(b_req_rdy),
    .o_add_val(b_add_val), .o_add_pt_a(b_add_pt_a), .o_add_pt_b(b_add_pt_b), .o_add_tag(b_add_tag),
    .i_add_rdy(b_add_rdy), .i_res_val(b_res_val), .i_res_pt(b_res_pt), .i_res_tag(b_res_tag),
    .o_res_rdy(b_res_rdy), .o_req_res_val(b_req_res_val), .o_req_res_pt(b_req_res_pt),
    .i_req_res_rdy(b_req_res_rdy), .o_inflight(b_inflight), .o_err(b_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model for instance A
  typedef struct { logic [1:0] tag; logic [DW-1:0] sum; int due; } res_t;
  res_t          add_q[$];
  int            m_ptr, m_inflight, m_outstanding, cyc;
  bit            m_full;
  logic [1:0]    m_tag;
  logic [DW-1:0] m_a, m_b;

  task automatic m_reset();
    m_ptr = 3; m_full = 0; m_inflight = 0; m_outstanding = 0; cyc = 0;
    add_q.delete();
  endtask

  task automatic model_pick(output logic [3:0] oh, output int idx);
    oh = '0; idx = -1;
    if ((m_full && !a_add_rdy) || m_outstanding >= 16) return;
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (a_req_val[j]) begin oh[j] = 1'b1; idx = j; return; end
    end
  endtask

  task automatic model_commit();
    logic [3:0] oh;
    int idx;
    bit add_hs, res_hs;
    model_pick(oh, idx);
    add_hs = m_full && a_add_rdy;
    res_hs = a_res_val && a_req_res_rdy[a_res_tag];
    if (add_hs) begin
      add_q.push_back('{m_tag, m_a + m_b, cyc + int'($urandom_range(1, 5))});
      m_inflight++;
    end
    if (res_hs) begin
      if (add_q.size() > 0) void'(add_q.pop_front());
      m_outstanding--;
      if (m_inflight > 0) m_inflight--;
    end
    if (idx >= 0) begin
      m_full = 1; m_ptr = idx; m_tag = 2'(idx); m_outstanding++;
      m_a = a_req_pt_a[idx*DW +: DW];
      m_b = a_req_pt_b[idx*DW +: DW];
    end else if (add_hs) begin
      m_full = 0;
    end
    cyc++;
  endtask

  task automatic a_idle();
    a_req_val = '0; a_add_rdy = 0; a_res_val = 0; a_res_tag = '0; a_res_pt = '0; a_req_res_rdy = '0;
    a_req_pt_a = '0; a_req_pt_b = '0;
  endtask

  task automatic b_idle();
    b_req_val = '0; b_add_rdy = 0; b_res_val = 0; b_res_tag = '0; b_res_pt = '0; b_req_res_rdy = '0;
    b_req_pt_a = '0; b_req_pt_b = '0;
  endtask

  task automatic rand_pts();
    for (int i = 0; i < 8; i++) begin
      a_req_pt_a[i*32 +: 32] = $urandom;
      a_req_pt_b[i*32 +: 32] = $urandom;
    end
    for (int i = 0; i < 6; i++) begin
      b_req_pt_a[i*32 +: 32] = $urandom;
      b_req_pt_b[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_idle(); b_idle();
    a_req_val = 4'hf; a_add_rdy = 1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (a_req_rdy !== 4'h0) $display("FAIL reset_req_rdy: got %b want 0000", a_req_rdy); else n_pass++;
    n_checks++; if (a_add_val !== 1'b0) $display("FAIL reset_add_val: got %b want 0", a_add_val); else n_pass++;
    n_checks++; if (a_add_pt_a !== '0 || a_add_pt_b !== '0 || a_add_tag !== '0)
      $display("FAIL reset_add_data: got %h/%h/%0d want 0", a_add_pt_a, a_add_pt_b, a_add_tag); else n_pass++;
    n_checks++; if (a_inflight !== 8'd0 || a_err !== 1'b0)
      $display("FAIL reset_cnt_err: got %0d/%b want 0/0", a_inflight, a_err); else n_pass++;
    n_checks++; if (b_add_val !== 1'b0 || b_inflight !== 8'd0 || b_err !== 1'b0)
      $display("FAIL reset_b: got %b/%0d/%b want 0/0/0", b_add_val, b_inflight, b_err); else n_pass++;
    @(negedge clk);
    a_idle();
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_fairness();
    logic [3:0] e;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_req_val = 4'hf; a_add_rdy = 1; rand_pts();
      #1;
      e = '0; e[k % 4] = 1'b1;
      n_checks++; if (a_req_rdy !== e) $display("FAIL fair_grant[%0d]: got %b want %b", k, a_req_rdy, e); else n_pass++;
      if (k > 0) begin
        n_checks++; if (a_add_val !== 1'b1 || a_add_tag !== 2'((k - 1) % 4))
          $display("FAIL fair_tag[%0d]: got %b/%0d want 1/%0d", k, a_add_val, a_add_tag, (k - 1) % 4); else n_pass++;
      end
      model_commit();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] sa, sb;
    @(negedge clk);
    a_req_val = 4'b0100; a_add_rdy = 1; rand_pts();
    #1;
    n_checks++; if (a_req_rdy !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", a_req_rdy); else n_pass++;
    sa = a_req_pt_a[2*DW +: DW]; sb = a_req_pt_b[2*DW +: DW];
    model_commit();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_req_val = 4'hf; a_add_rdy = 0; rand_pts();
      #1;
      n_checks++; if (a_req_rdy !== 4'h0) $display("FAIL bp_no_grant[%0d]: got %b want 0000", k, a_req_rdy); else n_pass++;
      n_checks++; if (a_add_val !== 1'b1 || a_add_tag !== 2'd2 || a_add_pt_a !== sa || a_add_pt_b !== sb)
        $display("FAIL bp_hold[%0d]: got %b/%0d/%h/%h want 1/2/%h/%h", k, a_add_val, a_add_tag, a_add_pt_a, a_add_pt_b, sa, sb);
      else n_pass++;
      model_commit();
    end
    @(negedge clk);
    a_req_val = 4'h0; a_add_rdy = 1;
    #1;
    n_checks++; if (a_add_val !== 1'b1 || a_add_pt_a !== sa) $display("FAIL bp_issue: got %b/%h want 1/%h", a_add_val, a_add_pt_a, sa); else n_pass++;
    model_commit();
    @(negedge clk);
    a_add_rdy = 0;
    #1;
    n_checks++; if (a_add_val !== 1'b0 || a_inflight !== 8'd9)
      $display("FAIL bp_after: got %b/%0d want 0/9", a_add_val, a_inflight); else n_pass++;
    model_commit();
  endtask

  task automatic test_routing();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_res_val = 1; a_res_tag = 2'd3; a_res_pt = 64'hdead_beef_0123_4567; a_req_res_rdy = 4'b0111;
      #1;
      n_checks++; if (a_req_res_val !== 4'b1000 || a_res_rdy !== 1'b0)
        $display("FAIL route_stall[%0d]: got %b/%b want 1000/0", k, a_req_res_val, a_res_rdy); else n_pass++;
      n_checks++; if (a_req_res_pt !== 64'hdead_beef_0123_4567 || a_inflight !== 8'd9)
        $display("FAIL route_pt[%0d]: got %h/%0d want deadbeef01234567/9", k, a_req_res_pt, a_inflight); else n_pass++;
      model_commit();
    end
    @(negedge clk);
    a_req_res_rdy = 4'b1111;
    #1;
    n_checks++; if (a_res_rdy !== 1'b1) $display("FAIL route_rdy: got %b want 1", a_res_rdy); else n_pass++;
    model_commit();
    @(negedge clk);
    a_res_val = 0;
    #1;
    n_checks++; if (a_inflight !== 8'd8) $display("FAIL route_dec: got %0d want 8", a_inflight); else n_pass++;
    model_commit();
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_res_val = 1; a_res_tag = 2'd0; a_req_res_rdy = 4'hf;
      #1; model_commit();
    end
    @(negedge clk);
    a_res_val = 0; a_req_val = 4'b0010; a_add_rdy = 0; rand_pts();
    #1;
    n_checks++; if (a_req_rdy !== 4'b0010) $display("FAIL mid_pre_grant: got %b want 0010", a_req_rdy); else n_pass++;
    model_commit();
    @(negedge clk);
    a_req_val = 4'hf; a_add_rdy = 0;
    #1;
    n_checks++; if (a_add_val !== 1'b1 || a_inflight !== 8'd5)
      $display("FAIL mid_pre_state: got %b/%0d want 1/5", a_add_val, a_inflight); else n_pass++;
    #2;
    rst = 1'b0;
    a_res_val = 1; a_res_tag = 2'd1;
    #1;
    n_checks++; if (a_add_val !== 1'b0 || a_add_pt_a !== '0 || a_add_pt_b !== '0 || a_add_tag !== '0)
      $display("FAIL mid_rst_add: got %b/%h/%h/%0d want all 0", a_add_val, a_add_pt_a, a_add_pt_b, a_add_tag); else n_pass++;
    n_checks++; if (a_inflight !== 8'd0 || a_err !== 1'b0 || a_req_rdy !== 4'h0)
      $display("FAIL mid_rst_cnt: got %0d/%b/%b want 0/0/0000", a_inflight, a_err, a_req_rdy); else n_pass++;
    n_checks++; if (a_res_rdy !== 1'b0 || a_req_res_val !== 4'h0)
      $display("FAIL mid_rst_res: got %b/%b want 0/0000", a_res_rdy, a_req_res_val); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    a_idle();
    m_reset();
    a_req_val = 4'hf; a_add_rdy = 1; rand_pts();
    #1;
    n_checks++; if (a_req_rdy !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", a_req_rdy); else n_pass++;
    model_commit();
  endtask

  task automatic test_random();
    logic [3:0] eg, erv;
    int idx;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a_req_val = 4'($urandom); rand_pts();
      a_add_rdy = ($urandom_range(0, 3) != 0);
      a_req_res_rdy = (i < 200 || $urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if (add_q.size() > 0 && add_q[0].due <= cyc) begin
        a_res_val = 1; a_res_tag = add_q[0].tag; a_res_pt = add_q[0].sum;
      end else begin
        a_res_val = 0; a_res_tag = 2'($urandom); a_res_pt = {$urandom, $urandom};
      end
      #1;
      model_pick(eg, idx);
      erv = '0; if (a_res_val) erv[a_res_tag] = 1'b1;
      n_checks++; if (a_req_rdy !== eg) $display("FAIL rnd_grant[%0d]: got %b want %b", i, a_req_rdy, eg); else n_pass++;
      n_checks++; if (a_add_val !== m_full) $display("FAIL rnd_add_val[%0d]: got %b want %b", i, a_add_val, m_full); else n_pass++;
      if (m_full) begin
        n_checks++; if (a_add_tag !== m_tag || a_add_pt_a !== m_a || a_add_pt_b !== m_b)
          $display("FAIL rnd_add_data[%0d]: got %0d/%h/%h want %0d/%h/%h", i, a_add_tag, a_add_pt_a, a_add_pt_b, m_tag, m_a, m_b);
        else n_pass++;
      end
      n_checks++; if (a_inflight !== 8'(m_inflight)) $display("FAIL rnd_inflight[%0d]: got %0d want %0d", i, a_inflight, m_inflight); else n_pass++;
      n_checks++; if (a_req_res_val !== erv) $display("FAIL rnd_res_val[%0d]: got %b want %b", i, a_req_res_val, erv); else n_pass++;
      if (a_res_val) begin
        n_checks++; if (a_res_rdy !== a_req_res_rdy[a_res_tag] || a_req_res_pt !== add_q[0].sum)
          $display("FAIL rnd_res_rdy[%0d]: got %b/%h want %b/%h", i, a_res_rdy, a_req_res_pt, a_req_res_rdy[a_res_tag], add_q[0].sum);
        else n_pass++;
      end
      model_commit();
    end
    n_checks++; if (a_err !== 1'b0) $display("FAIL rnd_err: got %b want 0", a_err); else n_pass++;
    @(negedge clk);
    a_idle();
  endtask

  task automatic test_credit();
    int hs = 0, gr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      b_req_val = 3'b111; b_add_rdy = 1; b_res_val = 0; rand_pts();
      #1;
      if (b_add_val) hs++;
      if (b_req_rdy != 3'b000) gr++;
      n_checks++; if (b_inflight > 8'd4) $display("FAIL credit_cap[%0d]: got %0d want <=4", k, b_inflight); else n_pass++;
    end
    n_checks++; if (hs != 4 || gr != 4) $display("FAIL credit_count: got hs=%0d gr=%0d want 4/4", hs, gr); else n_pass++;
    n_checks++; if (b_inflight !== 8'd4 || b_req_rdy !== 3'b000)
      $display("FAIL credit_full: got %0d/%b want 4/000", b_inflight, b_req_rdy); else n_pass++;
    hs = 0; gr = 0;
    @(negedge clk);
    b_res_val = 1; b_res_tag = 2'd0; b_req_res_rdy = 3'b111;
    #1;
    n_checks++; if (b_res_rdy !== 1'b1) $display("FAIL credit_res_rdy: got %b want 1", b_res_rdy); else n_pass++;
    if (b_req_rdy != 3'b000) gr++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b_res_val = 0; rand_pts();
      #1;
      if (b_add_val) hs++;
      if (b_req_rdy != 3'b000) gr++;
    end
    n_checks++; if (gr != 1 || hs != 1 || b_inflight !== 8'd4)
      $display("FAIL credit_refill: got gr=%0d hs=%0d infl=%0d want 1/1/4", gr, hs, b_inflight); else n_pass++;
  endtask

  task automatic test_error();
    @(negedge clk);
    b_req_val = 3'b000; b_res_val = 0;
    #1;
    n_checks++; if (b_err !== 1'b0) $display("FAIL err_pre: got %b want 0", b_err); else n_pass++;
    @(negedge clk);
    b_res_val = 1; b_res_tag = 2'd3; b_req_res_rdy = 3'b000;
    #1;
    n_checks++; if (b_res_rdy !== 1'b1 || b_req_res_val !== 3'b000)
      $display("FAIL err_drop: got %b/%b want 1/000", b_res_rdy, b_req_res_val); else n_pass++;
    @(negedge clk);
    b_res_val = 0;
    #1;
    n_checks++; if (b_err !== 1'b1) $display("FAIL err_set: got %b want 1", b_err); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b_req_val = 3'($urandom); b_add_rdy = 1; rand_pts();
    end
    #1;
    n_checks++; if (b_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", b_err); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (b_err !== 1'b0) $display("FAIL err_clear: got %b want 0", b_err); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_routing();
    test_reset_midstream();
    test_random();
    test_credit();
    test_error();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
